// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RISC-V pipeline.
// Accepts one instruction at a time from EX/MEM. Non-memory and misaligned
// instructions pass straight into MEM/WB. Aligned loads and stores issue a
// registered request on the data-memory port and stall upstream until the
// memory acknowledges. Load data is lane-selected and extended before it is
// registered into MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  // EX/MEM slot
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_to_reg,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  // upstream hold
  output logic        mem_stall,
  // data-memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  // MEM/WB register
  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic        misalign_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state_reg;
  logic [0:0]  state_next;

  // Instruction fields captured when a memory access is accepted, so the
  // writeback values do not depend on upstream holding its outputs.
  logic [31:0] alu_result_reg;
  logic [2:0]  funct3_reg;
  logic        mem_read_reg;
  logic        mem_to_reg_reg;
  logic        reg_write_reg;
  logic [4:0]  rd_reg;

  // Registered memory port.
  logic        req_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  // Registered MEM/WB outputs.
  logic        wb_valid_reg;
  logic [31:0] wb_alu_result_reg;
  logic [31:0] wb_mem_data_reg;
  logic        wb_mem_to_reg_reg;
  logic        wb_reg_write_reg;
  logic [4:0]  wb_rd_reg;
  logic        misalign_err_reg;

  logic        is_mem;
  logic        misaligned;
  logic        misalign_now;
  logic        accept;
  logic        in_idle;
  logic [1:0]  byte_off;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign in_idle      = (state_reg == IDLE);
  assign is_mem       = in_valid && (in_mem_read || in_mem_write);
  assign byte_off     = in_alu_result[1:0];
  assign misalign_now = is_mem && misaligned;
  // Only an aligned memory op in IDLE starts a bus access.
  assign accept       = in_idle && is_mem && !misaligned;

  // Halfwords need an even address, words a 4-byte-aligned one.
  always_comb begin
    misaligned = 1'b0;
    case (in_funct3[1:0])
      2'b01:   misaligned = in_alu_result[0];
      2'b10:   misaligned = |in_alu_result[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Hold upstream while an access is being issued or is still outstanding.
  always_comb begin
    mem_stall = 1'b0;
    if (in_idle) begin
      mem_stall = accept;
    end else begin
      mem_stall = !dmem_ack;
    end
  end

  // Per-lane store data replication and byte strobes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign store_wdata[gi*8 +: 8] =
        (in_funct3[1:0] == 2'b00) ? in_store_data[7:0] :
        (in_funct3[1:0] == 2'b01) ? in_store_data[(gi % 2)*8 +: 8] :
                                    in_store_data[gi*8 +: 8];
      assign store_wstrb[gi] = in_mem_write && (
        (in_funct3[1:0] == 2'b00) ? (byte_off == LANE) :
        (in_funct3[1:0] == 2'b01) ? (in_alu_result[1] == LANE[1]) :
                                    1'b1);
    end
  endgenerate

  // Select the addressed byte/halfword of the returned word and extend it.
  always_comb begin
    load_byte = dmem_rdata[{alu_result_reg[1:0], 3'b000} +: 8];
    load_half = alu_result_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (funct3_reg)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = dmem_rdata;
    endcase
    if (!mem_read_reg) begin
      load_data = 32'h0;
    end
  end

  // Next-state logic: leave IDLE on an accepted access, return on ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = accept ? WAIT : IDLE;
      WAIT:    state_next = dmem_ack ? IDLE : WAIT;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the accepted instruction's writeback fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_reg <= 32'h0;
      funct3_reg     <= 3'b000;
      mem_read_reg   <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
      rd_reg         <= 5'd0;
    end else if (accept) begin
      alu_result_reg <= in_alu_result;
      funct3_reg     <= in_funct3;
      mem_read_reg   <= in_mem_read;
      mem_to_reg_reg <= in_mem_to_reg;
      reg_write_reg  <= in_reg_write;
      rd_reg         <= in_rd;
    end
  end

  // Memory port: raise the request on accept, drop it after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'h0;
    end else if (accept) begin
      req_reg   <= 1'b1;
      we_reg    <= in_mem_write;
      addr_reg  <= {in_alu_result[31:2], 2'b00};
      wdata_reg <= store_wdata;
      wstrb_reg <= store_wstrb;
    end else if (!in_idle && dmem_ack) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      wstrb_reg <= 4'h0;
    end
  end

  // MEM/WB register: load a completed instruction or a bubble every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg      <= 1'b0;
      wb_alu_result_reg <= 32'h0;
      wb_mem_data_reg   <= 32'h0;
      wb_mem_to_reg_reg <= 1'b0;
      wb_reg_write_reg  <= 1'b0;
      wb_rd_reg         <= 5'd0;
      misalign_err_reg  <= 1'b0;
    end else if (!in_idle && dmem_ack) begin
      wb_valid_reg      <= 1'b1;
      wb_alu_result_reg <= alu_result_reg;
      wb_mem_data_reg   <= load_data;
      wb_mem_to_reg_reg <= mem_to_reg_reg;
      wb_reg_write_reg  <= reg_write_reg;
      wb_rd_reg         <= rd_reg;
      misalign_err_reg  <= 1'b0;
    end else if (in_idle && in_valid && !accept) begin
      wb_valid_reg      <= 1'b1;
      wb_alu_result_reg <= in_alu_result;
      wb_mem_data_reg   <= 32'h0;
      wb_mem_to_reg_reg <= in_mem_to_reg;
      wb_reg_write_reg  <= in_reg_write && !misalign_now;
      wb_rd_reg         <= in_rd;
      misalign_err_reg  <= misalign_now;
    end else begin
      wb_valid_reg      <= 1'b0;
      wb_alu_result_reg <= 32'h0;
      wb_mem_data_reg   <= 32'h0;
      wb_mem_to_reg_reg <= 1'b0;
      wb_reg_write_reg  <= 1'b0;
      wb_rd_reg         <= 5'd0;
      misalign_err_reg  <= 1'b0;
    end
  end

  assign dmem_req      = req_reg;
  assign dmem_we       = we_reg;
  assign dmem_addr     = addr_reg;
  assign dmem_wdata    = wdata_reg;
  assign dmem_wstrb    = wstrb_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_alu_result = wb_alu_result_reg;
  assign wb_mem_data   = wb_mem_data_reg;
  assign wb_mem_to_reg = wb_mem_to_reg_reg;
  assign wb_reg_write  = wb_reg_write_reg;
  assign wb_rd         = wb_rd_reg;
  assign misalign_err  = misalign_err_reg;

endmodule
